edge_det_multi: RTL and testbench

//   Parametrised, multi-channel successor to the single-channel touch edge detector.

---
 rtl/edge_det_multi.sv | 117 +++++++++++
 tb/tb_edge_det_multi.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/edge_det_multi.sv
// edge_det_multi: multi-channel synchronised, debounced edge detector.
// Each channel emits a one-cycle pulse on a selected edge type and can latch it into a sticky flag.
//
// Parameters:
//   N_CH        number of independent channels (>=1)
//   SYNC_STAGES synchroniser flops per channel (>=2)
//   DEB_CYCLES  consecutive differing samples needed to accept a new level (>=1)
// Ports:
//   clk      system clock, posedge
//   rstn     asynchronous active-low reset
//   cin      raw asynchronous inputs, one bit per channel
//   mode     per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   evt_clr  per-channel sticky flag clear (level)
//   lvl      debounced level per channel
//   cout     one-cycle edge pulse per channel
//   evt      sticky event flags
//   irq      OR of all sticky flags
module edge_det_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_CH-1:0]   cin,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   evt_clr,
  output logic [N_CH-1:0]   lvl,
  output logic [N_CH-1:0]   cout,
  output logic [N_CH-1:0]   evt,
  output logic              irq
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch

    logic [SYNC_STAGES-1:0] sr;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_d;
    logic                   l;
    logic                   l_d;
    logic                   acc;
    logic                   rise;
    logic                   fall;
    logic                   p;
    logic                   p_d;
    logic                   e;
    logic                   e_d;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sr <= '0;
      end else begin
        sr <= {sr[SYNC_STAGES-2:0], cin[i]};
      end
    end

    assign s = sr[SYNC_STAGES-1];

    // The counter only advances while the synchronised input disagrees
    // with the accepted level; any agreeing sample restarts it.
    always_comb begin
      cnt_d = cnt;
      l_d   = l;
      acc   = 1'b0;
      unique case (1'b1)
        (s == l): begin
          cnt_d = '0;
        end
        (s != l) && (cnt != CMAX): begin
          cnt_d = cnt + CW'(1);
        end
        (s != l) && (cnt == CMAX): begin
          cnt_d = '0;
          l_d   = s;
          acc   = 1'b1;
        end
      endcase
      rise = acc & s;
      fall = acc & ~s;
      p_d  = (rise & mode[2*i]) | (fall & mode[2*i+1]);
      // A new pulse wins over a clear arriving in the same cycle.
      if (p_d) begin
        e_d = 1'b1;
      end else if (evt_clr[i]) begin
        e_d = 1'b0;
      end else begin
        e_d = e;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt <= '0;
        l   <= 1'b0;
        p   <= 1'b0;
        e   <= 1'b0;
      end else begin
        cnt <= cnt_d;
        l   <= l_d;
        p   <= p_d;
        e   <= e_d;
      end
    end

    assign lvl[i]  = l;
    assign cout[i] = p;
    assign evt[i]  = e;

  end

  assign irq = |evt;

endmodule

// File: tb/tb_edge_det_multi.sv
// tb_edge_det_multi: directed bench for edge_det_multi.
// Linear sequence of steps with hand-computed expectations.
module tb_edge_det_multi;

  logic       clk;
  logic       rstn;
  logic [3:0] cin;
  logic [7:0] mode;
  logic [3:0] evt_clr;
  logic [3:0] lvl;
  logic [3:0] cout;
  logic [3:0] evt;
  logic       irq;

  int total = 0;
  int bad   = 0;
  int c;

  edge_det_multi #(
    .N_CH(4),
    .SYNC_STAGES(2),
    .DEB_CYCLES(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cin(cin),
    .mode(mode),
    .evt_clr(evt_clr),
    .lvl(lvl),
    .cout(cout),
    .evt(evt),
    .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advances n cycles, counting cycles where any masked cout bit is high.
  task automatic count(input int n, input logic [3:0] m, output int k);
    k = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if ((cout & m) != 4'b0) k++;
    end
  endtask

  initial begin
    rstn    = 1'b0;
    cin     = 4'b0;
    mode    = 8'b0;
    evt_clr = 4'b0;
    #20;
    chk("rst_lvl", {28'b0, lvl}, 32'h0);
    chk("rst_cout", {28'b0, cout}, 32'h0);
    chk("rst_evt", {28'b0, evt}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rstn = 1'b1;
    tick(1);

    // 1: ch0 rising, pulse on 6th edge after the drive
    mode = 8'b00_11_10_01;
    cin  = 4'b0001;
    tick(5);
    chk("t1_pre_cout", {28'b0, cout}, 32'h0);
    chk("t1_pre_lvl", {28'b0, lvl}, 32'h0);
    tick(1);
    chk("t1_cout", {28'b0, cout}, 32'h1);
    chk("t1_lvl", {28'b0, lvl}, 32'h1);
    chk("t1_evt", {28'b0, evt}, 32'h1);
    chk("t1_irq", {31'b0, irq}, 32'h1);
    tick(1);
    chk("t1_cout_1cyc", {28'b0, cout}, 32'h0);
    chk("t1_evt_hold", {28'b0, evt}, 32'h1);

    // 2: ch1 falling-only
    cin = 4'b0011;
    count(20, 4'b0010, c);
    chk("t2_no_rise", c, 0);
    chk("t2_lvl_hi", {28'b0, lvl}, 32'h3);
    chk("t2_evt_no", {28'b0, evt}, 32'h1);
    cin = 4'b0001;
    tick(5);
    chk("t2_pre_cout", {28'b0, cout}, 32'h0);
    tick(1);
    chk("t2_cout", {28'b0, cout}, 32'h2);
    chk("t2_lvl", {28'b0, lvl}, 32'h1);
    chk("t2_evt", {28'b0, evt}, 32'h3);

    // 3: ch2 both edges, short glitch first
    cin = 4'b0101;
    tick(3);
    cin = 4'b0001;
    begin
      int g = 0;
      repeat (10) begin
        tick(1);
        if (cout[2] || lvl[2]) g++;
      end
      chk("t3_glitch", g, 0);
    end
    cin = 4'b0101;
    count(10, 4'b0100, c);
    chk("t3_rise_cnt", c, 1);
    chk("t3_lvl_hi", {28'b0, lvl}, 32'h5);
    cin = 4'b0001;
    count(15, 4'b0100, c);
    chk("t3_fall_cnt", c, 1);
    chk("t3_lvl_lo", {28'b0, lvl}, 32'h1);
    chk("t3_evt", {28'b0, evt}, 32'h7);

    // 4: clear vs set precedence
    evt_clr = 4'b1111;
    tick(1);
    evt_clr = 4'b0000;
    chk("t4_clr_all", {28'b0, evt}, 32'h0);
    chk("t4_irq_lo", {31'b0, irq}, 32'h0);
    cin = 4'b0000;
    count(12, 4'b1111, c);
    chk("t4_no_fall", c, 0);
    chk("t4_lvl0", {28'b0, lvl}, 32'h0);
    chk("t4_evt0", {28'b0, evt}, 32'h0);
    cin = 4'b0001;
    tick(5);
    chk("t4_pre_cout", {28'b0, cout}, 32'h0);
    evt_clr = 4'b0001;
    tick(1);
    chk("t4_cout", {28'b0, cout}, 32'h1);
    chk("t4_set_wins", {28'b0, evt}, 32'h1);
    chk("t4_irq_hi", {31'b0, irq}, 32'h1);
    tick(1);
    chk("t4_cleared", {28'b0, evt}, 32'h0);
    chk("t4_irq_drop", {31'b0, irq}, 32'h0);
    evt_clr = 4'b0000;

    // 5: all channels off, level still tracks
    mode = 8'h00;
    cin  = 4'b1010;
    count(8, 4'b1111, c);
    chk("t5_off_a", c, 0);
    chk("t5_lvl_a", {28'b0, lvl}, 32'ha);
    cin = 4'b0101;
    count(8, 4'b1111, c);
    chk("t5_off_b", c, 0);
    chk("t5_lvl_b", {28'b0, lvl}, 32'h5);
    chk("t5_evt", {28'b0, evt}, 32'h0);
    mode = 8'hff;
    count(8, 4'b1111, c);
    chk("t5_mode_sw", c, 0);
    chk("t5_evt_sw", {28'b0, evt}, 32'h0);
    chk("t5_irq", {31'b0, irq}, 32'h0);

    // 6: reset in the middle of a debounce on ch1
    mode = 8'b00_00_01_00;
    cin  = 4'b0111;
    tick(3);
    rstn = 1'b0;
    #1;
    chk("t6_rst_lvl", {28'b0, lvl}, 32'h0);
    chk("t6_rst_cout", {28'b0, cout}, 32'h0);
    chk("t6_rst_irq", {31'b0, irq}, 32'h0);
    tick(2);
    rstn = 1'b1;
    tick(5);
    chk("t6_pre_lvl", {28'b0, lvl}, 32'h0);
    chk("t6_pre_cout", {28'b0, cout}, 32'h0);
    tick(1);
    chk("t6_cout", {28'b0, cout}, 32'h2);
    chk("t6_lvl", {28'b0, lvl}, 32'h7);
    chk("t6_evt", {28'b0, evt}, 32'h2);
    tick(1);
    chk("t6_cout_1cyc", {28'b0, cout}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
